// File: rtl/crc4_serial_tx.sv
// crc4_serial_tx: serialises a parallel message MSB first and appends its
// CRC-4 (MSB first), computed on the fly as the message bits are accepted.
module crc4_serial_tx #(
  parameter int unsigned MSG_W = 7,
  parameter logic [3:0]  POLY  = 4'b0011
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [MSG_W-1:0] msg_in,
  output logic             ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic [3:0]       crc_out,
  output logic             done
);

  // Counter covers the message index and the 4-bit CRC phase.
  localparam int unsigned CNT_W = ($clog2(MSG_W) < 2) ? 2 : $clog2(MSG_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CRC,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [MSG_W-1:0]   r_shreg;
  logic [3:0]         r_crc;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_crc_out;
  logic               r_ready;
  logic               r_ser_out;
  logic               r_ser_valid;
  logic               r_done;

  logic               w_fb;
  logic [3:0]         w_crc_nx;
  logic [MSG_W-1:0]   w_shreg_nx;
  logic [CNT_W-1:0]   w_cnt_dec;

  // Next CRC / shift values for the bit currently on the line.
  assign w_fb       = r_shreg[MSG_W-1] ^ r_crc[3];
  assign w_crc_nx   = {r_crc[2:0], 1'b0} ^ (w_fb ? POLY : 4'b0000);
  assign w_shreg_nx = r_shreg << 1;
  assign w_cnt_dec  = r_cnt - CNT_W'(1);

  // Frame sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_crc       <= 4'b0000;
      r_cnt       <= '0;
      r_crc_out   <= 4'b0000;
      r_ready     <= 1'b1;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shreg     <= msg_in;
            r_crc       <= 4'b0000;
            r_crc_out   <= 4'b0000;
            r_cnt       <= CNT_W'(MSG_W - 1);
            r_ready     <= 1'b0;
            r_ser_valid <= 1'b1;
            r_ser_out   <= msg_in[MSG_W-1];
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (ser_ready) begin
            r_crc   <= w_crc_nx;
            r_shreg <= w_shreg_nx;
            if (r_cnt == '0) begin
              r_cnt     <= CNT_W'(3);
              r_ser_out <= w_crc_nx[3];
              r_state   <= S_CRC;
            end else begin
              r_cnt     <= w_cnt_dec;
              r_ser_out <= w_shreg_nx[MSG_W-1];
            end
          end
        end
        S_CRC: begin
          if (ser_ready) begin
            if (r_cnt == '0) begin
              r_ser_valid <= 1'b0;
              r_ser_out   <= 1'b0;
              r_done      <= 1'b1;
              r_crc_out   <= r_crc;
              r_state     <= S_DONE;
            end else begin
              r_cnt     <= w_cnt_dec;
              r_ser_out <= r_crc[w_cnt_dec[1:0]];
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done      <= 1'b0;
          r_ser_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign crc_out   = r_crc_out;
  assign done      = r_done;

endmodule

// File: doc/crc4_serial_tx.md
Name: crc4_serial_tx

Overview:
- Transmit-side counterpart of the team's serial CRC-4 checker.
- Accepts a parallel message word and shifts it out serially, MSB first.
- Computes CRC-4 (polynomial x^4+x+1, init 0000, no reflection, no final XOR) on the fly and appends the 4 CRC bits, MSB first.
- Sits between a message source and a serial link. A frame fed to the checker yields a remainder of 0000.

Parameters:
- MSG_W, 7, message width in bits (>= 1).
- POLY, 4'b0011, low 4 bits of the generator polynomial; x^4 term implied.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request to send msg_in; sampled only when ready=1.
- msg_in  input  MSG_W  message word; captured on the accepted start.
- ready  output  1  1 = idle, can accept start.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit.
- ser_ready  input  1  downstream accepts the current bit this cycle.
- crc_out  output  4  CRC of the last completed frame; held until the next accepted start.
- done  output  1  one-cycle pulse after the last CRC bit is accepted.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - ready=1; ser_out, ser_valid, done = 0; crc_out = 0000.
  - Internal shift register, CRC register and bit counter are cleared.
  - Reset mid-frame aborts the frame immediately. No done pulse; crc_out is 0000.
- States:
  - IDLE: ready=1, ser_valid=0. If start=1 at a rising edge, load msg_in into the shift register, clear the CRC register and crc_out, set count=MSG_W-1, go to DATA.
  - DATA: ser_valid=1, ser_out = shreg[MSG_W-1]. On each edge with ser_ready=1:
    - fb = ser_out ^ crc[3].
    - crc <= {crc[2:0],1'b0} ^ (fb ? POLY : 0).
    - Shift the register left and decrement count.
    - When count was 0, go to CRC with count=3.
  - CRC: ser_valid=1, ser_out = crc[count]. The CRC register is frozen. On ser_ready=1, decrement count; when count was 0, go to DONE.
  - DONE: done=1, ser_valid=0, ready=0. crc_out <= crc register. Go to IDLE next cycle.
- Latency:
  - The first bit appears the cycle after start is accepted.
  - Frame length is MSG_W+4 accepted bits.
  - With ser_ready tied to 1, done occurs MSG_W+5 cycles after the start edge.
- Stall: ser_ready=0 holds ser_out and ser_valid and freezes all state. Stalls may be any length, in either DATA or CRC.
- start while ready=0 is ignored, including during DONE. There is no queueing.
- msg_in is don't-care except on the accepted start edge.
- All outputs are registered or decoded from state only. There is no combinational path from start or ser_ready to outputs.
- Bit counter is $clog2(MSG_W) bits wide, minimum 2 bits to cover the CRC phase.

Test Plan:
- Reset: assert reset_n=0 mid-DATA of a frame -> outputs go to their reset values immediately, with no done pulse. After release, ready=1 and crc_out=0000.
- Message 7'b1011001, ser_ready=1:
  - ser_out sequence is 1,0,1,1,0,0,1 then 1,0,1,0.
  - ser_valid is high for exactly 11 cycles.
  - done pulses at cycle 12 after the start edge; crc_out=4'hA.
- Message 7'b1000000 -> CRC bits 0,1,1,1; crc_out=4'h7. Message 7'b0000000 -> 11 zero bits; crc_out=4'h0.
- Stall:
  - 1011001 with ser_ready=0 for 3 cycles during bit 3 and 2 cycles during CRC bit 1.
  - Accepted bit stream is identical to the unstalled case; ser_out is stable during stalls.
  - done is delayed by 5 cycles.
- Start protocol:
  - start held high continuously -> frames run back to back with one IDLE cycle between DONE and the next accept.
  - A start pulse mid-frame is ignored, and msg_in changes mid-frame do not alter the stream.
- Loopback: drive ser_out/ser_valid into the serial CRC-4 checker for random 7-bit messages -> checker remainder = 0000 after the 11 bits; crc_out matches the reference model.
